// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_flags: default geometry, depth derivation and
// threshold legality functions used at elaboration.
package sync_fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int AF_THRESH_DEF = 12;
  localparam int AE_THRESH_DEF = 2;

  // Pointers carry one extra wrap bit; count spans 0..DEPTH inclusive.
  typedef logic [ADDR_SIZE_DEF:0] def_ptr_t;
  typedef logic [ADDR_SIZE_DEF:0] def_cnt_t;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic bit af_legal(input int af, input int addr_size);
    return (af >= 1) && (af <= fifo_depth(addr_size));
  endfunction

  function automatic bit ae_legal(input int ae, input int addr_size);
    return (ae >= 0) && (ae < fifo_depth(addr_size));
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write gated by wfull, asynchronous read.
module fifo_mem #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 wclk,
  input  logic                 wclken,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wfull,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

  assign rdata = mem[raddr];

  always_ff @(posedge wclk) begin
    if (wclken && !wfull) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] w_data,
  output logic                 w_full,
  output logic                 w_almost_full,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  typedef logic [ADDR_SIZE:0] ptr_t;
  typedef logic [ADDR_SIZE:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);

  if (!af_legal(AF_THRESH, ADDR_SIZE)) begin : g_af_illegal
    $error("sync_fifo_flags: AF_THRESH must lie in 1..DEPTH");
  end
  if (!ae_legal(AE_THRESH, ADDR_SIZE)) begin : g_ae_illegal
    $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
  end

  ptr_t w_ptr_q, w_ptr_d;
  ptr_t r_ptr_q, r_ptr_d;
  cnt_t count_q, count_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic                 wr_ok, rd_ok;
  logic [DATA_SIZE-1:0] mem_rdata;

  // Flags decode the registered count only, so they never glitch.
  assign w_full         = (count_q == DEPTH_C);
  assign w_almost_full  = (count_q >= AF_C);
  assign r_empty        = (count_q == '0);
  assign r_almost_empty = (count_q <= AE_C);
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  assign wr_ok = w_en && !w_full;
  assign rd_ok = r_en && !r_empty;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (w_en && w_full);
    underflow_d = underflow_q | (r_en && r_empty);
    if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // A write presented during reset must not land in the array.
  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .wclk   (clk),
    .wclken (w_en && rst),
    .waddr  (w_ptr_q[ADDR_SIZE-1:0]),
    .wdata  (w_data),
    .wfull  (w_full),
    .raddr  (r_ptr_q[ADDR_SIZE-1:0]),
    .rdata  (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data = mem_rdata;
`else
  logic [DATA_SIZE-1:0] r_data_q, r_data_d;

  always_comb begin
    r_data_d = r_data_q;
    if (rd_ok) r_data_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_data_q <= '0;
    else      r_data_q <= r_data_d;
  end

  assign r_data = r_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: vector table for the fill phase,
// scoreboard queue for read data, hand sequences for the corner cases.
module tb_sync_fifo_flags;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       w_full, w_almost_full, r_empty, r_almost_empty, overflow, underflow;
  logic [4:0] count;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DATA_SIZE (8),
    .ADDR_SIZE (4),
    .AF_THRESH (12),
    .AE_THRESH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .w_en           (w_en),
    .w_data         (w_data),
    .w_full         (w_full),
    .w_almost_full  (w_almost_full),
    .r_en           (r_en),
    .r_data         (r_data),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  def_cnt_t   m_count = '0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;

  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         re;
    def_cnt_t   e_cnt;
    bit         e_af;
    bit         e_full;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_flags();
    chk("count",          32'(count),          32'(m_count));
    chk("w_full",         32'(w_full),         32'(m_count == 16));
    chk("w_almost_full",  32'(w_almost_full),  32'(m_count >= 12));
    chk("r_empty",        32'(r_empty),        32'(m_count == 0));
    chk("r_almost_empty", 32'(r_almost_empty), 32'(m_count <= 2));
    chk("overflow",       32'(overflow),       32'(m_ovf));
    chk("underflow",      32'(underflow),      32'(m_unf));
  endtask

  // One clock: drive, (FWFT) check head before the edge, update model after it.
  task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit do_rst = 1'b0);
    bit         wok, rok;
    logic [7:0] exp;
    w_en   = we;
    w_data = wd;
    r_en   = re;
    rst    = ~do_rst;
    wok    = we && (m_count != 16);
    rok    = re && (m_count != 0);
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    if (rok && !do_rst) chk("fwft r_data", 32'(r_data), 32'(sb[0]));
`endif
    @(posedge clk);
    #1;
    if (do_rst) begin
      sb.delete();
      m_count = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      if (we && m_count == 16) m_ovf = 1'b1;
      if (re && m_count == 0)  m_unf = 1'b1;
      if (wok) sb.push_back(wd);
      if (rok) begin
        exp = sb.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        chk("r_data", 32'(r_data), 32'(exp));
`endif
      end
      if (wok && !rok) m_count = m_count + 1'b1;
      if (rok && !wok) m_count = m_count - 1'b1;
    end
    chk_flags();
    w_en = 1'b0;
    r_en = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].we     = 1'b1;
      tbl[i].wd     = 8'(i);
      tbl[i].re     = 1'b0;
      tbl[i].e_cnt  = def_cnt_t'(i + 1);
      tbl[i].e_af   = (i + 1) >= 12;
      tbl[i].e_full = (i == 15);
      tbl[i].e_ovf  = 1'b0;
    end
    tbl[16].we     = 1'b1;
    tbl[16].wd     = 8'hAA;
    tbl[16].re     = 1'b0;
    tbl[16].e_cnt  = 5'd16;
    tbl[16].e_af   = 1'b1;
    tbl[16].e_full = 1'b1;
    tbl[16].e_ovf  = 1'b1;

    // Reset then idle
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst r_empty", 32'(r_empty), 32'd1);
    chk("rst r_almost_empty", 32'(r_almost_empty), 32'd1);
    chk("rst w_full", 32'(w_full), 32'd0);
    chk("rst w_almost_full", 32'(w_almost_full), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst underflow", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst r_data", 32'(r_data), 32'd0);
`endif

    // Fill 0x00..0x0F, then a rejected 0xAA
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].we, tbl[i].wd, tbl[i].re);
      chk("tbl count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl w_almost_full", 32'(w_almost_full), 32'(tbl[i].e_af));
      chk("tbl w_full", 32'(w_full), 32'(tbl[i].e_full));
      chk("tbl overflow", 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Full: read wins, write rejected; then drain remaining 15
    step(1'b1, 8'h55, 1'b1);
    chk("full rw count", 32'(count), 32'd15);
    chk("full rw overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    chk("drained r_empty", 32'(r_empty), 32'd1);
    chk("drained sb empty", 32'(sb.size()), 32'd0);

    // Empty: write wins, read rejected
    step(1'b1, 8'h3C, 1'b1);
    chk("empty rw underflow", 32'(underflow), 32'd1);
    chk("empty rw count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft head 3C", 32'(r_data), 32'h3C);
`endif
    step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("read 3C", 32'(r_data), 32'h3C);
`endif

    // Wrap-around stream at steady count 3
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h90 + i), 1'b1);
      chk("wrap count", 32'(count), 32'd3);
      chk("wrap errs", 32'({overflow, underflow}), 32'd0);
    end

    // Mid-stream reset at count 9, with a write presented that cycle
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre-rst count", 32'(count), 32'd9);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("mid rst count", 32'(count), 32'd0);
    chk("mid rst r_empty", 32'(r_empty), 32'd1);
    chk("mid rst errs", 32'({overflow, underflow}), 32'd0);
    step(1'b1, 8'h7E, 1'b0);
    step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("read 7E", 32'(r_data), 32'h7E);
`endif
    chk("final r_empty", 32'(r_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, for same-domain buffering between pipeline stages.
- Adds the following over the dual-clock FIFO:
  - live occupancy count
  - almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - optional first-word-fall-through read mode
- Pointers are binary; Gray coding and synchronisers are not needed.

Parameters:
- DATA_SIZE, 8, word width in bits.
- ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE words.
- AF_THRESH, 12, w_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, r_almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- w_en  in  1  write request.
- w_data  in  DATA_SIZE  write word.
- w_full  out  1  count == DEPTH.
- w_almost_full  out  1  count >= AF_THRESH.
- r_en  in  1  read request; acknowledge when FWFT_EN is defined.
- r_data  out  DATA_SIZE  read word.
- r_empty  out  1  count == 0.
- r_almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst==0 at a clk edge):
  - w_ptr, r_ptr, count, r_data, overflow, underflow all cleared to 0.
  - Resulting outputs: r_empty=1, r_almost_empty=1, w_full=0, w_almost_full=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words and any request presented in that cycle.
- Pointers: w_ptr and r_ptr are ADDR_SIZE+1 bits. The low ADDR_SIZE bits address memory; the MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- Write acceptance: wr_ok = w_en && !w_full. Memory is written at w_ptr[ADDR_SIZE-1:0] and w_ptr increments.
- Read acceptance: rd_ok = r_en && !r_empty. r_ptr increments.
- Count update, registered:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither occur
- Flags: all four are combinational decodes of the registered count, so they are glitch-free and update the cycle after the causing edge.
- Simultaneous read and write:
  - When full: the read is accepted and the write is rejected (w_full was 1). Overflow sets; count goes DEPTH -> DEPTH-1.
  - When empty: the write is accepted and the read is rejected. Underflow sets; count goes 0 -> 1.
- Error flags:
  - overflow sets on w_en && w_full.
  - underflow sets on r_en && r_empty.
  - Both clear only on reset.
  - A rejected request leaves pointers, count and memory unchanged.
- Read latency without FWFT_EN:
  - r_data is a register loaded with mem[r_ptr] on rd_ok, valid the cycle after the accepted read.
  - r_data holds its value otherwise, including on rejected reads.
- Write-to-read latency: a word written at edge N is readable (r_empty=0) from edge N onward, i.e. r_en may be accepted at edge N+1.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined:
  - r_data = mem[r_ptr] combinationally whenever r_empty==0; r_en pops the current word.
  - A word written into an empty FIFO at edge N appears on r_data in the cycle after edge N, with zero added latency.
  - r_data while r_empty==1 is don't-care and is not checked.
- Undefined: registered one-cycle read latency, as described under Behaviour.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - localparam DEPTH derivation helper
  - typedef for the pointer (ADDR_SIZE+1 bits)
  - typedef for count
  - elaboration-time threshold legality checks (assert AF_THRESH in 1..DEPTH, AE_THRESH < DEPTH)
- Sub-module: reuse the team's fifo_mem dual-port array for storage:
  - clk drives its write clock.
  - w_full gates its write.
  - It has an asynchronous read port.
- Pointer, count, flag and read-register logic live in sync_fifo_flags itself.

Test Plan (DATA_SIZE=8, ADDR_SIZE=4, AF_THRESH=12, AE_THRESH=2):
- Reset, then idle -> count=0, r_empty=1, r_almost_empty=1, w_full=0, w_almost_full=0, overflow=0, underflow=0.
- Write 0x00..0x0F on 16 consecutive cycles:
  - w_almost_full rises the cycle count reaches 12.
  - w_full=1 at count=16.
  - A 17th write of 0xAA -> overflow=1, count stays 16.
  - Draining then returns 0x00..0x0F in order (0xAA absent).
- At count=16, assert w_en and r_en together with w_data=0x55 -> read accepted, write rejected, count=15, overflow=1.
- With FIFO empty, assert r_en together with w_en, w_data=0x3C:
  - underflow=1, count=1.
  - Next read returns 0x3C: one cycle after r_en without the macro, immediately with SYNC_FIFO_FWFT_EN.
- Wrap-around: 40 words streamed with continuous simultaneous read and write at steady count=3 -> data order preserved across pointer wrap; count constant at 3; no error flags set.
- Assert rst=0 for one cycle at count=9 mid-stream -> next cycle count=0, r_empty=1, overflow=0, underflow=0; subsequent write/read of 0x7E returns 0x7E.
